// File: rtl/div.sv
// Restoring shift-subtract divider: one quotient bit per clock, ready_o 33 cycles after start is taken (1 for divide-by-zero).
// The caller holds start_i until it sees ready_o; the result stays put until start_i drops, and annul_i abandons a running divide.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [64:0] work, work_n;
  logic [31:0] divisor, divisor_n;
  logic        q_neg, q_neg_n;
  logic        r_neg, r_neg_n;
  logic [63:0] result_n;
  logic        ready_n;

  logic [31:0] op1_abs, op2_abs;
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [31:0] quot, rem;

  assign op1_abs = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

  // Trial subtraction on the shifted partial remainder; diff[32] set means it went negative.
  assign shifted = work << 1;
  assign diff    = shifted[64:32] - {1'b0, divisor};

  assign quot = q_neg ? -work[31:0]  : work[31:0];
  assign rem  = r_neg ? -work[63:32] : work[63:32];

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    work_n    = work;
    divisor_n = divisor;
    q_neg_n   = q_neg;
    r_neg_n   = r_neg;
    result_n  = result_o;
    ready_n   = ready_o;
    case (state)
      FREE: begin
        ready_n  = 1'b0;
        result_n = 64'd0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_n = BY_ZERO;
          end else begin
            state_n   = ON;
            cnt_n     = 6'd0;
            work_n    = {33'd0, op1_abs};
            divisor_n = op2_abs;
            q_neg_n   = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            r_neg_n   = signed_div_i && opdata1_i[31];
          end
        end
      end
      BY_ZERO: begin
        state_n  = END;
        result_n = 64'd0;
        ready_n  = 1'b1;
      end
      ON: begin
        if (annul_i) begin
          state_n  = FREE;
          result_n = 64'd0;
          ready_n  = 1'b0;
        end else if (cnt != 6'd32) begin
          if (!diff[32]) work_n = {diff, shifted[31:0] | 32'd1};
          else           work_n = shifted;
          cnt_n = cnt + 6'd1;
        end else begin
          result_n = {rem, quot};
          ready_n  = 1'b1;
          cnt_n    = 6'd0;
          state_n  = END;
        end
      end
      END: begin
        if (!start_i) begin
          state_n  = FREE;
          ready_n  = 1'b0;
          result_n = 64'd0;
        end
      end
      default: state_n = FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      work     <= 65'd0;
      divisor  <= 32'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      work     <= work_n;
      divisor  <= divisor_n;
      q_neg    <= q_neg_n;
      r_neg    <= r_neg_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div.sv
// Randomised and directed bench for div, checked each cycle against an arithmetic reference.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic        exp_rdy = 1'b0;
  logic [63:0] exp_res = 64'd0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference result: integer division truncating toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {63'd0, ready_o}, {63'd0, exp_rdy});
      chk("result", result_o, exp_res);
    end
  end

  task automatic scramble();
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom);
  endtask

  // annul_at < 0 means no annul; on annul, returns with start_i still high.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int annul_at, input int hold);
    logic [63:0] res;
    int lat;
    res = model(a, b, s);
    lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_div_i = s;
    start_i = 1'b1; annul_i = 1'b0;
    for (int n = 0; n <= lat; n++) begin
      if (n > 0) begin
        @(negedge clk);
        scramble();
      end
      if (n == annul_at) annul_i = 1'b1;
      @(posedge clk);
      #1;
      if (n == annul_at) begin
        annul_i = 1'b0;
        return;
      end
      if (n >= lat) begin
        exp_rdy = 1'b1;
        exp_res = res;
      end
    end
    repeat (hold) begin
      @(negedge clk);
      scramble();
      @(posedge clk);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    exp_rdy = 1'b0;
    exp_res = 64'd0;
  endtask

  task automatic rst_after(input logic [31:0] a, input logic [31:0] b, input logic s, input int edges);
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_div_i = s;
    start_i = 1'b1; annul_i = 1'b0;
    for (int n = 0; n < edges; n++) begin
      @(posedge clk);
      #1;
      if (n >= 33) begin
        exp_rdy = 1'b1;
        exp_res = model(a, b, s);
      end
    end
    #2;
    rst = 1'b1;
    exp_rdy = 1'b0;
    exp_res = 64'd0;
    #1;
    chk("async_rst_ready", {63'd0, ready_o}, 64'd0);
    chk("async_rst_result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic s;
    rst = 1'b1;
    start_i = 1'b0; annul_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0; signed_div_i = 1'b0;

    chk("model_u100_7",    model(32'd100, 32'd7, 1'b0),              64'h00000002_0000000E);
    chk("model_s-7_2",     model(32'hFFFFFFF9, 32'd2, 1'b1),         64'hFFFFFFFF_FFFFFFFD);
    chk("model_s7_-2",     model(32'd7, 32'hFFFFFFFE, 1'b1),         64'h00000001_FFFFFFFD);
    chk("model_s_wrap",    model(32'h80000000, 32'hFFFFFFFF, 1'b1),  64'h00000000_80000000);
    chk("model_u_max",     model(32'hFFFFFFFF, 32'd1, 1'b0),         64'h00000000_FFFFFFFF);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, -1, 3);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, -1, 1);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, -1, 0);
    run_div(32'h12345678, 32'd0, 1'b0, -1, 2);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, -1, 1);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, -1, 0);

    run_div(32'd555, 32'd9, 1'b0, 10, 0);
    run_div(32'd100, 32'd7, 1'b0, -1, 2);

    rst_after(32'd1000, 32'd3, 1'b0, 20);
    run_div(32'd100, 32'd7, 1'b0, -1, 1);
    rst_after(32'hFFFFFF00, 32'd5, 1'b1, 36);
    run_div(32'hFFFFFF00, 32'd5, 1'b1, -1, 1);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      s = 1'($urandom);
      if (b != 32'd0 && $urandom_range(0, 7) == 0)
        run_div(a, b, s, $urandom_range(1, 32), 0);
      else
        run_div(a, b, s, -1, $urandom_range(0, 3));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
